// File: rtl/cpu_mem_responder.sv
// Memory-side responder for the CPU core: Harvard code/data arrays with
// programmable wait states, stalling the core through enable.
//
// state      | meaning
// -----------+---------------------------------------------------------
// IDLE       | enable high, sampling fetch and load/store requests
// DATA_WAIT  | load/store counting down, may hand over to a pending fetch
// FETCH_WAIT | instruction fetch counting down
module cpu_mem_responder #(
    parameter int ADDR_BITS     = 16,
    parameter int FETCH_LATENCY = 1,
    parameter int DATA_LATENCY  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          instruction_address,
    input  logic                 instruction_enable,
    output logic [31:0]          instr,
    input  logic [31:0]          address,
    input  logic                 read_enable,
    input  logic                 write_enable,
    input  logic [31:0]          write_data,
    input  logic [3:0]           byte_enables,
    output logic [31:0]          read_data,
    output logic                 enable,
    input  logic                 halted,
    input  logic                 preload_en,
    input  logic                 preload_sel,
    input  logic [ADDR_BITS-1:0] preload_addr,
    input  logic [31:0]          preload_data,
    output logic                 access_error
);

    localparam int          DEPTH          = 1 << ADDR_BITS;
    localparam int          HI_SHIFT       = ADDR_BITS + 2;
    localparam logic [31:0] NOP            = 32'h0000_0013;
    localparam logic [3:0]  DATA_CNT_INIT  = 4'(DATA_LATENCY - 1);
    localparam logic [3:0]  FETCH_CNT_INIT = 4'(FETCH_LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        DATA_WAIT  = 2'd1,
        FETCH_WAIT = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [31:0] code_mem [DEPTH];
    logic [31:0] data_mem [DEPTH];

    logic [3:0]           wait_cnt;
    logic [ADDR_BITS-1:0] data_idx;
    logic [ADDR_BITS-1:0] fetch_idx;
    logic [31:0]          store_data;
    logic [3:0]           store_mask;
    logic                 is_store;
    logic                 fetch_pending;

    logic        data_req;
    logic        accept;
    logic        accept_data;
    logic        accept_fetch_only;
    logic        cnt_zero;
    logic        data_done;
    logic        fetch_done;
    logic        data_addr_bad;
    logic        fetch_addr_bad;
    logic        req_err;
    logic [31:0] store_word;

    // Request decode and completion strobes.
    always_comb begin
        data_req          = read_enable | write_enable;
        accept            = (state == IDLE) && enable && !halted;
        accept_data       = accept && data_req;
        accept_fetch_only = accept && !data_req && instruction_enable;
        cnt_zero          = (wait_cnt == 4'd0);
        data_done         = (state == DATA_WAIT) && cnt_zero;
        fetch_done        = (state == FETCH_WAIT) && cnt_zero;
        data_addr_bad     = (address >> HI_SHIFT) != 32'd0;
        fetch_addr_bad    = ((instruction_address >> HI_SHIFT) != 32'd0)
                            || (instruction_address[1:0] != 2'b00);
        req_err           = accept && ((data_req && data_addr_bad)
                                       || (instruction_enable && fetch_addr_bad)
                                       || (read_enable && write_enable));
    end

    // Lane merge for a store completing this cycle.
    always_comb begin
        store_word = data_mem[data_idx];
        for (int i = 0; i < 4; i++) begin
            if (store_mask[i]) begin
                store_word[8*i +: 8] = store_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept_data) begin
                    state_next = DATA_WAIT;
                end else if (accept_fetch_only) begin
                    state_next = FETCH_WAIT;
                end
            end
            DATA_WAIT: begin
                if (cnt_zero) begin
                    state_next = fetch_pending ? FETCH_WAIT : IDLE;
                end
            end
            FETCH_WAIT: begin
                if (cnt_zero) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            enable        <= 1'b0;
            instr         <= NOP;
            read_data     <= 32'd0;
            access_error  <= 1'b0;
            wait_cnt      <= 4'd0;
            data_idx      <= '0;
            fetch_idx     <= '0;
            store_data    <= 32'd0;
            store_mask    <= 4'd0;
            is_store      <= 1'b0;
            fetch_pending <= 1'b0;
        end else begin
            if (req_err) begin
                access_error <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (accept_data) begin
                        data_idx      <= address[ADDR_BITS+1:2];
                        fetch_idx     <= instruction_address[ADDR_BITS+1:2];
                        store_data    <= write_data;
                        store_mask    <= byte_enables;
                        is_store      <= write_enable;
                        fetch_pending <= instruction_enable;
                        wait_cnt      <= DATA_CNT_INIT;
                        enable        <= 1'b0;
                    end else if (accept_fetch_only) begin
                        fetch_idx     <= instruction_address[ADDR_BITS+1:2];
                        fetch_pending <= 1'b0;
                        wait_cnt      <= FETCH_CNT_INIT;
                        enable        <= 1'b0;
                    end else begin
                        enable <= 1'b1;
                    end
                end
                DATA_WAIT: begin
                    if (cnt_zero) begin
                        if (!is_store) begin
                            read_data <= data_mem[data_idx];
                        end
                        if (fetch_pending) begin
                            fetch_pending <= 1'b0;
                            wait_cnt      <= FETCH_CNT_INIT;
                        end else begin
                            enable <= 1'b1;
                        end
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                FETCH_WAIT: begin
                    if (cnt_zero) begin
                        instr  <= code_mem[fetch_idx];
                        enable <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                default: enable <= 1'b0;
            endcase
        end
    end

    // Arrays are never cleared; the store is written last so it beats a
    // same-cycle preload of the same word.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (preload_en && !preload_sel) begin
                code_mem[preload_addr] <= preload_data;
            end
            if (preload_en && preload_sel) begin
                data_mem[preload_addr] <= preload_data;
            end
            if (data_done && is_store) begin
                data_mem[data_idx] <= store_word;
            end
        end
    end

endmodule
